// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic unit arbiter: opcode encodings, default
// logic unit latency and a constant-evaluable clog2.
package logic_unit_arbiter_pkg;

    // Encodings are shared with unit_logic_opt; NOT inverts operand A.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } lu_op_e;

    localparam int LU_LAT_DEF = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter_core.sv
// Round-robin grant core: rr pointer plus a rotating priority search that
// yields a one-hot grant and its encoded requester ID.
module rr_arbiter_core
    import logic_unit_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_valid,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_id,
    output logic            o_grant_valid
);

    logic [IDW-1:0]  r_rr_ptr;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_id;
    logic            w_found;
    int              w_idx;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && i_valid[w_idx]) begin
                w_found         = 1'b1;
                w_grant[w_idx]  = 1'b1;
                w_grant_id      = IDW'(w_idx);
            end
        end
        if (rst) begin
            w_grant = '0;
            w_found = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + IDW'(1);
        end
    end

    assign o_grant       = w_grant;
    assign o_grant_id    = w_grant_id;
    assign o_grant_valid = w_found;

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one fixed-latency logic unit between NREQ requesters with round-robin
// issue and ID-tagged responses. Optional statistics under LOGIC_ARB_STATS_EN.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREQ   = 4,
    parameter int LU_LAT = LU_LAT_DEF,
    parameter int IDW    = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_opcode,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  lu_v_in,
    output logic [1:0]            lu_opcode,
    output logic [WIDTH-1:0]      lu_a,
    output logic [WIDTH-1:0]      lu_b,
    input  logic [WIDTH-1:0]      lu_out,
    input  logic                  lu_v_out,
    output logic                  err_sync
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [16*NREQ-1:0]    stat_grants,
    output logic [15:0]           stat_stalls
`endif
);

    localparam int WARM_W = clog2(LU_LAT + 1);

    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_grant_id;
    logic              w_grant_valid;
    logic [LU_LAT-1:0] r_tag_valid;
    logic [IDW-1:0]    r_tag_id [LU_LAT];
    logic              w_last_valid;
    logic [IDW-1:0]    w_last_id;
    logic [WARM_W-1:0] r_warm;
    logic              w_warm_done;

    rr_arbiter_core #(.NREQ(NREQ), .IDW(IDW)) u_core (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (req_valid),
        .o_grant      (w_grant),
        .o_grant_id   (w_grant_id),
        .o_grant_valid(w_grant_valid)
    );

    assign req_ready = w_grant;
    assign lu_v_in   = w_grant_valid;

    always_comb begin
        lu_opcode = '0;
        lu_a      = '0;
        lu_b      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                lu_opcode = req_opcode[2*i +: 2];
                lu_a      = req_a[WIDTH*i +: WIDTH];
                lu_b      = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_valid <= '0;
        end else begin
            r_tag_valid[0] <= w_grant_valid;
            for (int s = 1; s < LU_LAT; s++) r_tag_valid[s] <= r_tag_valid[s-1];
        end
    end

    // NOTE: IDs carry no reset; they are only ever read when their valid bit is set.
    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_grant_id;
        for (int s = 1; s < LU_LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
    end

    assign w_last_valid = r_tag_valid[LU_LAT-1];
    assign w_last_id    = r_tag_id[LU_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= '0;
            if (w_last_valid) begin
                resp_valid[w_last_id] <= 1'b1;
                resp_data             <= lu_out;
            end
        end
    end

    // The unreset logic unit may emit stale valids right after reset; skip those cycles.
    assign w_warm_done = (r_warm == WARM_W'(LU_LAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm   <= '0;
            err_sync <= 1'b0;
        end else begin
            if (!w_warm_done) r_warm <= r_warm + WARM_W'(1);
            if (w_warm_done && (lu_v_out != w_last_valid)) err_sync <= 1'b1;
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    logic w_stall;
    assign w_stall = |(req_valid & ~req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_grant[i] && (stat_grants[16*i +: 16] != 16'hFFFF))
                    stat_grants[16*i +: 16] <= stat_grants[16*i +: 16] + 16'd1;
            end
            if (w_stall && (stat_stalls != 16'hFFFF)) stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a 2-cycle behavioural logic unit.
module tb_logic_unit_arbiter;
    import logic_unit_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_opcode;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   resp_valid;
    logic [31:0]  resp_data;
    logic         lu_v_in;
    logic [1:0]   lu_opcode;
    logic [31:0]  lu_a;
    logic [31:0]  lu_b;
    logic [31:0]  lu_out;
    logic         lu_v_out;
    logic         err_sync;
`ifdef LOGIC_ARB_STATS_EN
    logic [63:0]  stat_grants;
    logic [15:0]  stat_stalls;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opcode(req_opcode),
        .req_a     (req_a),
        .req_b     (req_b),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .lu_v_in   (lu_v_in),
        .lu_opcode (lu_opcode),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_out    (lu_out),
        .lu_v_out  (lu_v_out),
        .err_sync  (err_sync)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stalls(stat_stalls)
`endif
    );

    // Behavioural logic unit: two register stages, no reset.
    logic        m_v1 = 1'b0, m_v2 = 1'b0, force_v = 1'b0;
    logic [31:0] m_res1 = '0, m_res2 = '0;

    function automatic logic [31:0] lu_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    always @(posedge clk) begin
        m_v1   <= lu_v_in;
        m_v2   <= m_v1;
        m_res1 <= lu_f(lu_opcode, lu_a, lu_b);
        m_res2 <= m_res1;
    end

    assign lu_out   = m_res2;
    assign lu_v_out = m_v2 | force_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_opcode[2*i +: 2] = op;
        req_a[32*i +: 32]    = a;
        req_b[32*i +: 32]    = b;
    endtask

    logic [31:0] fair_exp [4];
    logic [31:0] b2b_exp  [5];
    logic [3:0]  exp_r;
    int          id;

    initial begin
        fair_exp = '{32'h0F000F00, 32'h000000FF, 32'h55555555, 32'hFFFF0000};
        b2b_exp  = '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'hFFFFFFF7, 32'hFFFFFFEF};

        // Reset held three cycles with every requester asking.
        rst        = 1'b1;
        req_valid  = 4'hF;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            mid();
            check("rst_ready", 32'(req_ready), 32'h0);
            check("rst_lu_v_in", 32'(lu_v_in), 32'h0);
            check("rst_resp_valid", 32'(resp_valid), 32'h0);
            check("rst_err_sync", 32'(err_sync), 32'h0);
        end

        tick();
        rst       = 1'b0;
        req_valid = 4'h0;
        set_req(0, OP_OR, 32'hDEADBEEF, 32'h1);
        mid();
        check("idle_lu_v_in", 32'(lu_v_in), 32'h0);
        check("idle_lu_opcode", 32'(lu_opcode), 32'h0);
        check("idle_lu_a", lu_a, 32'h0);
        check("idle_lu_b", lu_b, 32'h0);
        repeat (3) tick();

        // Single XOR on requester 2.
        tick();
        req_valid = 4'b0100;
        set_req(2, OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F);
        mid();
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_lu_v_in", 32'(lu_v_in), 32'h1);
        check("single_lu_opcode", 32'(lu_opcode), 32'h2);
        check("single_lu_a", lu_a, 32'hFFFF0000);
        check("single_lu_b", lu_b, 32'h0F0F0F0F);
        for (int c = 1; c <= 4; c++) begin
            tick();
            req_valid = 4'h0;
            mid();
            check("single_resp_valid", 32'(resp_valid), (c == 3) ? 32'h4 : 32'h0);
            if (c == 3) check("single_resp_data", resp_data, 32'hF0F00F0F);
        end

        // Requester 3 alone first so the pointer wraps to 0, then all four.
        set_req(0, OP_AND, 32'hFF00FF00, 32'h0FF00FF0);
        set_req(1, OP_OR,  32'h000000F0, 32'h0000000F);
        set_req(2, OP_XOR, 32'hAAAAAAAA, 32'hFFFFFFFF);
        set_req(3, OP_NOT, 32'h0000FFFF, 32'h12345678);
        tick();
        req_valid = 4'b1000;
        mid();
        check("wrap_ready", 32'(req_ready), 32'h8);
        for (int k = 0; k < 11; k++) begin
            tick();
            req_valid = (k < 8) ? 4'hF : 4'h0;
            mid();
            exp_r = (k < 8) ? 4'(1 << (k % 4)) : 4'h0;
            check("fair_ready", 32'(req_ready), 32'(exp_r));
            if (k >= 2) begin
                id = (k + 1) % 4;
                check("fair_resp_valid", 32'(resp_valid), 32'(1 << id));
                check("fair_resp_data", resp_data, fair_exp[id]);
            end else begin
                check("fair_resp_idle", 32'(resp_valid), 32'h0);
            end
        end
        tick();
        mid();
        check("fair_drain", 32'(resp_valid), 32'h0);

        // Back-to-back on requester 1, no bubbles.
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 5) begin
                req_valid = 4'b0010;
                set_req(1, OP_XOR, 32'h1 << k, 32'hFFFFFFFF);
            end else begin
                req_valid = 4'h0;
            end
            mid();
            check("b2b_ready", 32'(req_ready), (k < 5) ? 32'h2 : 32'h0);
            if (k >= 3) begin
                check("b2b_resp_valid", 32'(resp_valid), 32'h2);
                check("b2b_resp_data", resp_data, b2b_exp[k-3]);
            end else begin
                check("b2b_resp_idle", 32'(resp_valid), 32'h0);
            end
        end

        // Reset while two operations are in flight.
        tick();
        req_valid = 4'b0001;
        set_req(0, OP_AND, 32'hFFFFFFFF, 32'h12345678);
        mid();
        check("mid_ready0", 32'(req_ready), 32'h1);
        tick();
        set_req(0, OP_AND, 32'hFFFFFFFF, 32'h87654321);
        mid();
        check("mid_ready1", 32'(req_ready), 32'h1);
        tick();
        rst = 1'b1;
        mid();
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        check("mid_rst_lu_v_in", 32'(lu_v_in), 32'h0);
        for (int c = 3; c <= 5; c++) begin
            tick();
            rst       = 1'b0;
            req_valid = 4'h0;
            mid();
            check("mid_resp_dropped", 32'(resp_valid), 32'h0);
            check("mid_err_sync", 32'(err_sync), 32'h0);
        end

        // Spurious lu_v_out after warm-up sets the sticky error.
        repeat (3) tick();
        mid();
        check("sync_pre", 32'(err_sync), 32'h0);
        tick();
        force_v = 1'b1;
        mid();
        check("sync_same_cycle", 32'(err_sync), 32'h0);
        tick();
        force_v = 1'b0;
        mid();
        check("sync_rise", 32'(err_sync), 32'h1);
        tick();
        mid();
        check("sync_sticky", 32'(err_sync), 32'h1);
        tick();
        rst = 1'b1;
        mid();
        tick();
        rst = 1'b0;
        mid();
        check("sync_cleared", 32'(err_sync), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one pipelined_logic_io instance (fixed 2-cycle latency, no backpressure, no reset) between NREQ requesters.
- Round-robin issues at most one operation per cycle, tracks each in-flight operation's requester ID, and returns results on a shared response bus with a one-hot valid.
- Sits between the requester ports and the logic unit in the ALU top level.

Parameters:
- WIDTH, 32, operand and result width; must match the logic unit.
- NREQ, 4, number of requesters (2..8).
- LU_LAT, 2, logic unit latency in cycles from v_in to v_out.
- IDW, 2, requester ID width, equal to clog2(NREQ).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_opcode  in  2*NREQ  packed opcodes; requester i uses bits [2i+:2].
- req_a  in  WIDTH*NREQ  packed operand A.
- req_b  in  WIDTH*NREQ  packed operand B.
- resp_valid  out  NREQ  one-hot result valid; result is owned by the set bit.
- resp_data  out  WIDTH  result; shared by all requesters.
- lu_v_in  out  1  logic unit valid.
- lu_opcode  out  2  logic unit opcode.
- lu_a  out  WIDTH  logic unit operand A.
- lu_b  out  WIDTH  logic unit operand B.
- lu_out  in  WIDTH  logic unit result.
- lu_v_out  in  1  logic unit result valid.
- err_sync  out  1  sticky valid-mismatch flag.

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: rr_ptr=0, tag pipe all invalid, resp_valid=0, resp_data=0, err_sync=0.
- req_ready is combinational and depends only on req_valid and rr_ptr. Requesters must not make req_valid depend on req_ready.
- Arbitration: search requesters rr_ptr, rr_ptr+1, … modulo NREQ. The first one with req_valid set gets req_ready.
- Accept = req_valid & req_ready. On accept of requester g, rr_ptr <= (g+1) mod NREQ. With no accept, rr_ptr holds.
- While rst is high, req_ready=0 and lu_v_in=0.
- Issue path is combinational:
  - lu_v_in = |(req_valid & req_ready).
  - lu_opcode, lu_a, lu_b = fields of the granted requester.
  - When no grant, lu_opcode, lu_a, lu_b = 0.
- Tag pipe: LU_LAT stages of {valid, id}. Stage 0 loads {accept, g} each cycle; the other stages shift.
- Response: registered from the last tag stage and lu_out.
  - resp_valid[id] <= last.valid; all other bits 0.
  - resp_data <= lu_out when last.valid, else hold.
  - Latency: accept in cycle 0 gives resp_valid in cycle LU_LAT+1 (3 by default).
- Throughput is one operation per cycle. Responses are never stalled; requesters must sink them.
- Response validity comes from the tag pipe only. lu_v_out is not used to qualify results, because the logic unit is unreset.
- err_sync: sets when lu_v_out != last.valid, but only after LU_LAT cycles have elapsed since reset release (a warm-up counter). It stays set until rst.
- Reset mid-operation: the tag pipe clears, so in-flight results are dropped and no resp_valid follows.
- A single requester held valid is granted every cycle; rr_ptr keeps pointing past it.
- When all requesters are valid, grant order is 0,1,2,3,0,…

Optional Feature:
- Macro LOGIC_ARB_STATS_EN.
- When defined:
  - Adds per-requester 16-bit saturating grant counters, output on port stat_grants (16*NREQ, packed).
  - Adds a 16-bit saturating stall counter, incremented on each cycle where a requester has req_valid without req_ready.
  - All counters reset to 0 on rst.
- When undefined: the port and the logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include holds:
  - opcode localparams (AND/OR/XOR/NOT-style 2-bit encodings, shared with unit_logic_opt);
  - LU_LAT default;
  - the clog2 function.
- One sub-module, rr_arbiter_core: rr_ptr register plus rotating priority search, producing a one-hot grant and an encoded ID. The tag pipe and response register stay in the top level.

Test Plan:
- Reset: hold rst for 3 cycles with all req_valid high -> req_ready=0, lu_v_in=0, resp_valid=0, err_sync=0.
- Single requester: req 2, opcode XOR, a=0xFFFF0000, b=0x0F0F0F0F, accepted in cycle 0 -> resp_valid=4'b0100 and resp_data=0xF0F00F0F in cycle 3 only.
- Fairness: all 4 valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; responses return in the same order, 3 cycles later.
- Back-to-back: req 1 valid for 5 cycles with distinct operands -> 5 consecutive resp_valid=4'b0010 with matching results and no bubbles.
- Reset mid-flight: accept ops in cycles 0 and 1, assert rst in cycle 2 -> no resp_valid in cycles 3..5; err_sync stays 0.
- Sync error: with a model unit, force lu_v_out=1 when no op is in flight, after warm-up -> err_sync rises next cycle and stays high until rst.
